regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter that sits directly upstream of the register file and owns its single write port (`ctrl_writeEn`, `ctrl_writeReg`, `data_writeReg`). It merges two result sources:
- the in-order pipeline write-back, which has priority and no backpressure;
- the multi-cycle mult/div unit, which uses a valid/ready handshake into a one-entry holding register.

It also provides the holding register's RAW hazard flag, a starvation-driven pipeline stall, and a sticky protocol-error flag.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive cycles a held mult/div result may lose arbitration before `stall_pipe` asserts; legal range 1..15.
- `DROP_R0`, default 1: when 1, any write to r0 is discarded and never reaches the regfile.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `ctrl_resetn`  in  1  reset, asynchronous, active-low.
- `pipe_we`  in  1  pipeline write-back request.
- `pipe_rd`  in  5  pipeline destination register.
- `pipe_data`  in  32  pipeline result.
- `md_valid`  in  1  mult/div result valid.
- `md_rd`  in  5  mult/div destination register.
- `md_data`  in  32  mult/div result.
- `md_ready`  out  1  holding register empty; transfer occurs when `md_valid & md_ready` at posedge.
- `ctrl_readRegA`  in  5  decode-stage read address A, for hazard check.
- `ctrl_readRegB`  in  5  decode-stage read address B, for hazard check.
- `md_hazard`  out  1  combinational; asserted when `held`, `held_rd != 0`, and `held_rd` equals `ctrl_readRegA` or `ctrl_readRegB`.
- `stall_pipe`  out  1  registered; pipeline must not assert `pipe_we` while this is high.
- `err_overrun`  out  1  sticky; set when `pipe_we` is asserted while `stall_pipe` = 1.
- `ctrl_writeEn`  out  1  registered regfile write enable.
- `ctrl_writeReg`  out  5  registered regfile write address.
- `data_writeReg`  out  32  registered regfile write data.

## Operation
- State:
  - `held` (1 bit), `held_rd`, `held_data`;
  - starve counter `cnt` (4 bits);
  - the three registered write outputs, `stall_pipe`, `err_overrun`.
- `md_ready = ~held`.
- Effective requests:
  - pipe request = `pipe_we & ~stall_pipe & ~(DROP_R0 & pipe_rd==0)`.
  - held request = `held`.
- Write-port selection, evaluated each posedge:
  1. If pipe request: drive pipe write.
  2. Else if held request: drive held write and clear `held`.
  3. Else: `ctrl_writeEn` <= 0; address and data hold their previous values.
- While `stall_pipe` = 1, a held entry always wins the port.
- Pipe writes during stall are dropped and set `err_overrun`.
- Capture: on `md_valid & md_ready`:
  - if `DROP_R0 & md_rd==0`: accept and discard (handshake completes, `held` stays 0);
  - otherwise load `held_rd` / `held_data` and set `held`.
- Squash: if `held` is set at the start of a cycle and a pipe request targets `held_rd`, the held entry is cleared without writing, because the younger pipe write supersedes it. `cnt` is cleared.
- A capture in the same cycle as a pipe write to the same rd is not squashed; the captured entry is written later.
- Starvation:
  - `cnt` increments each cycle `held` is set and loses to a pipe request;
  - `cnt` clears when `held` clears;
  - `stall_pipe` <= 1 when `cnt` reaches `STARVE_LIMIT`;
  - `stall_pipe` <= 0 on the edge that drains the held entry.
- `err_overrun` clears only on reset.

## Timing
- Reset (asynchronous, immediate on `ctrl_resetn` = 0):
  - `held`=0, `cnt`=0, `ctrl_writeEn`=0, `ctrl_writeReg`=0, `data_writeReg`=0, `stall_pipe`=0, `err_overrun`=0.
  - Consequently `md_ready`=1 and `md_hazard`=0.
- Reset mid-operation:
  - any held entry is lost;
  - a write output in flight is cancelled the same instant;
  - no regfile write occurs after reset asserts.
- Pipe latency: request sampled at posedge k → write outputs valid from edge k until edge k+1 → regfile commits at its next write edge.
- Mult/div latency when uncontested:
  - captured at edge k;
  - `md_ready`=0 from edge k;
  - write outputs driven at edge k+1;
  - `md_ready`=1 again from edge k+1.
  - Throughput: one mult/div result per 2 cycles.
- `md_hazard` follows the read addresses combinationally in the same cycle; the pipeline stalls decode while it is high.
- Worst-case mult/div delay to the regfile: `STARVE_LIMIT` + 2 cycles after capture.

## Test plan
- Reset, then pipe_we with rd=5, data=0x00364908 for one cycle → next cycle `ctrl_writeEn`=1, `ctrl_writeReg`=5, `data_writeReg`=0x00364908; the following cycle `ctrl_writeEn`=0.
- md_valid with rd=7, data=0xDEADBEEF and no pipe traffic → `md_ready` drops for exactly one cycle; write outputs rd=7, 0xDEADBEEF one cycle after capture.
- Hold md rd=9 while pipe_we is high every cycle with rd≠9, `STARVE_LIMIT`=4 → `stall_pipe`=1 after 4 lost cycles; next cycle writes rd=9; `stall_pipe` drops the same edge.
- Held rd=3, then pipe write rd=3, data=0x11 → only 0x11 is written to r3; `held` clears; `md_ready` returns to 1.
- `DROP_R0`=1: pipe rd=0 and md rd=0 requests → `ctrl_writeEn` stays 0; the md handshake still completes.
- Held rd=12 with `ctrl_readRegA`=12 → `md_hazard`=1; then assert `ctrl_resetn`=0 mid-hold → `md_hazard`=0, `md_ready`=1, `ctrl_writeEn`=0 immediately.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter owning the single regfile write port: pipeline results have
// priority, mult/div results wait in a one-entry holding register.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter bit DROP_R0      = 1'b1,
  parameter int DATA_W       = 32
) (
  input  logic              clock,
  input  logic              ctrl_resetn,
  input  logic              pipe_we,
  input  logic [4:0]        pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              md_valid,
  input  logic [4:0]        md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  input  logic [4:0]        ctrl_readRegA,
  input  logic [4:0]        ctrl_readRegB,
  output logic              md_hazard,
  output logic              stall_pipe,
  output logic              err_overrun,
  output logic              ctrl_writeEn,
  output logic [4:0]        ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              held;
  logic [4:0]        heldRd;
  logic [DATA_W-1:0] heldData;
  logic [3:0]        cnt;

  logic       pipeReq;
  logic       heldWins;
  logic       squash;
  logic       captureKeep;
  logic [3:0] cntNext;

  assign md_ready  = ~held;
  assign md_hazard = held && (heldRd != 5'd0) &&
                     ((heldRd == ctrl_readRegA) || (heldRd == ctrl_readRegB));

  always_comb begin
    pipeReq     = pipe_we && !stall_pipe && !(DROP_R0 && (pipe_rd == 5'd0));
    heldWins    = held && !pipeReq;
    // A younger pipe write to the same register makes the held result stale.
    squash      = held && pipeReq && (pipe_rd == heldRd);
    captureKeep = md_valid && !held && !(DROP_R0 && (md_rd == 5'd0));
    cntNext     = cnt;
    if (!held || heldWins || squash) begin
      cntNext = 4'd0;
    end else begin
      cntNext = cnt + 4'd1;
    end
  end

  // ---- holding register control and write-port select ----
  always_ff @(posedge clock or negedge ctrl_resetn) begin
    if (!ctrl_resetn) begin
      held          <= 1'b0;
      cnt           <= 4'd0;
      stall_pipe    <= 1'b0;
      err_overrun   <= 1'b0;
      ctrl_writeEn  <= 1'b0;
      ctrl_writeReg <= 5'd0;
      data_writeReg <= '0;
    end else begin
      cnt <= cntNext;

      if (heldWins || squash) begin
        held <= 1'b0;
      end else if (captureKeep) begin
        held <= 1'b1;
      end

      if (heldWins) begin
        stall_pipe <= 1'b0;
      end else if (held && (cntNext == LIMIT)) begin
        stall_pipe <= 1'b1;
      end

      if (pipe_we && stall_pipe) begin
        err_overrun <= 1'b1;
      end

      if (pipeReq) begin
        ctrl_writeEn  <= 1'b1;
        ctrl_writeReg <= pipe_rd;
        data_writeReg <= pipe_data;
      end else if (held) begin
        ctrl_writeEn  <= 1'b1;
        ctrl_writeReg <= heldRd;
        data_writeReg <= heldData;
      end else begin
        ctrl_writeEn  <= 1'b0;
      end
    end
  end

  // ---- holding register payload (qualified by held, so left unreset) ----
  always_ff @(posedge clock) begin
    if (captureKeep) begin
      heldRd   <= md_rd;
      heldData <= md_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected regfile writes go into a
// queue that a negedge monitor drains; control outputs are checked inline.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        ctrl_resetn;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic        md_hazard;
  logic        stall_pipe;
  logic        err_overrun;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .DROP_R0(1'b1)) dut (
    .clock         (clock),
    .ctrl_resetn   (ctrl_resetn),
    .pipe_we       (pipe_we),
    .pipe_rd       (pipe_rd),
    .pipe_data     (pipe_data),
    .md_valid      (md_valid),
    .md_rd         (md_rd),
    .md_data       (md_data),
    .md_ready      (md_ready),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .md_hazard     (md_hazard),
    .stall_pipe    (stall_pipe),
    .err_overrun   (err_overrun),
    .ctrl_writeEn  (ctrl_writeEn),
    .ctrl_writeReg (ctrl_writeReg),
    .data_writeReg (data_writeReg)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t expQ[$];
  int  checks   = 0;
  int  failures = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expectWrite(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd   = rd;
    w.data = data;
    expQ.push_back(w);
  endtask

  // Scoreboard monitor: every cycle with a write enable consumes one expected write.
  always @(negedge clock) begin
    if (ctrl_resetn && ctrl_writeEn) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual rd=%0d data=0x%0h required no write",
                 ctrl_writeReg, data_writeReg);
      end else begin
        wr_t w;
        w = expQ.pop_front();
        chk("wr_reg", 32'(ctrl_writeReg), 32'(w.rd));
        chk("wr_data", data_writeReg, w.data);
      end
    end
  end

  initial begin
    ctrl_resetn   = 1'b0;
    pipe_we       = 1'b0;
    pipe_rd       = 5'd0;
    pipe_data     = 32'd0;
    md_valid      = 1'b0;
    md_rd         = 5'd0;
    md_data       = 32'd0;
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;

    // Reset state
    step();
    step();
    chk("rst_writeEn", 32'(ctrl_writeEn), 32'd0);
    chk("rst_writeReg", 32'(ctrl_writeReg), 32'd0);
    chk("rst_data", data_writeReg, 32'd0);
    chk("rst_md_ready", 32'(md_ready), 32'd1);
    chk("rst_hazard", 32'(md_hazard), 32'd0);
    chk("rst_stall", 32'(stall_pipe), 32'd0);
    chk("rst_err", 32'(err_overrun), 32'd0);
    ctrl_resetn = 1'b1;
    step();

    // Single pipeline write
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h0036_4908;
    expectWrite(5'd5, 32'h0036_4908);
    step();
    chk("pipe_we_on", 32'(ctrl_writeEn), 32'd1);
    pipe_we = 1'b0;
    step();
    chk("pipe_we_off", 32'(ctrl_writeEn), 32'd0);

    // Uncontested mult/div result
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'hDEAD_BEEF;
    chk("md_ready_pre", 32'(md_ready), 32'd1);
    expectWrite(5'd7, 32'hDEAD_BEEF);
    step();
    md_valid = 1'b0;
    chk("md_ready_held", 32'(md_ready), 32'd0);
    chk("md_no_wr_yet", 32'(ctrl_writeEn), 32'd0);
    step();
    chk("md_ready_back", 32'(md_ready), 32'd1);
    chk("md_wr_on", 32'(ctrl_writeEn), 32'd1);
    step();
    chk("md_wr_off", 32'(ctrl_writeEn), 32'd0);

    // Starvation: four lost cycles raise stall, then the held entry drains
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h9999_0009;
    step();
    md_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pipe_we = 1'b1; pipe_rd = 5'(10 + i); pipe_data = 32'h100 + 32'(i);
      expectWrite(5'(10 + i), 32'h100 + 32'(i));
      step();
      chk("starve_stall", 32'(stall_pipe), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("starve_md_ready", 32'(md_ready), 32'd0);
    chk("err_before", 32'(err_overrun), 32'd0);
    // Overrun while stalled: dropped, held entry still wins
    pipe_we = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h0000_0BAD;
    expectWrite(5'd9, 32'h9999_0009);
    step();
    pipe_we = 1'b0;
    chk("stall_drop", 32'(stall_pipe), 32'd0);
    chk("err_set", 32'(err_overrun), 32'd1);
    chk("drain_md_ready", 32'(md_ready), 32'd1);
    step();
    chk("drain_wr_off", 32'(ctrl_writeEn), 32'd0);
    chk("err_sticky", 32'(err_overrun), 32'd1);

    // Squash: younger pipe write to the held register supersedes it
    md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h0000_0033;
    step();
    md_valid = 1'b0;
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h0000_0011;
    expectWrite(5'd3, 32'h0000_0011);
    step();
    pipe_we = 1'b0;
    chk("squash_md_ready", 32'(md_ready), 32'd1);
    step();
    chk("squash_no_wr", 32'(ctrl_writeEn), 32'd0);
    step();

    // Same-cycle capture and pipe write to one register: both land, md last
    md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h0000_0044;
    pipe_we = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h0000_0040;
    expectWrite(5'd4, 32'h0000_0040);
    expectWrite(5'd4, 32'h0000_0044);
    step();
    md_valid = 1'b0; pipe_we = 1'b0;
    chk("same_md_ready", 32'(md_ready), 32'd0);
    step();
    chk("same_md_wr", 32'(ctrl_writeEn), 32'd1);
    step();

    // r0 writes are discarded, handshake still completes
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h0000_FFFF;
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h0000_EEEE;
    chk("r0_ready_pre", 32'(md_ready), 32'd1);
    step();
    pipe_we = 1'b0; md_valid = 1'b0;
    chk("r0_ready_post", 32'(md_ready), 32'd1);
    chk("r0_no_wr", 32'(ctrl_writeEn), 32'd0);
    step();
    chk("r0_no_wr2", 32'(ctrl_writeEn), 32'd0);

    // Hazard on held register, then asynchronous reset mid-hold
    ctrl_readRegA = 5'd12; ctrl_readRegB = 5'd1;
    md_valid = 1'b1; md_rd = 5'd12; md_data = 32'h0000_000C;
    pipe_we = 1'b1; pipe_rd = 5'd13; pipe_data = 32'h0000_000D;
    step();
    md_valid = 1'b0; pipe_we = 1'b0;
    chk("hazard_A", 32'(md_hazard), 32'd1);
    ctrl_readRegA = 5'd1; ctrl_readRegB = 5'd12;
    #1;
    chk("hazard_B", 32'(md_hazard), 32'd1);
    ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd3;
    #1;
    chk("hazard_none", 32'(md_hazard), 32'd0);
    ctrl_readRegA = 5'd12;
    chk("inflight_wr", 32'(ctrl_writeEn), 32'd1);
    ctrl_resetn = 1'b0;
    #1;
    chk("arst_hazard", 32'(md_hazard), 32'd0);
    chk("arst_md_ready", 32'(md_ready), 32'd1);
    chk("arst_writeEn", 32'(ctrl_writeEn), 32'd0);
    chk("arst_err", 32'(err_overrun), 32'd0);
    chk("arst_writeReg", 32'(ctrl_writeReg), 32'd0);
    step();
    step();
    ctrl_resetn = 1'b1;
    step();
    chk("post_rst_no_wr", 32'(ctrl_writeEn), 32'd0);
    step();
    chk("post_rst_no_wr2", 32'(ctrl_writeEn), 32'd0);

    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL pending_writes actual=%0d required=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
